// File: rtl/rf_writeback_queue_if.sv
// Handshake, write-port, hazard-check and occupancy bundle for rf_writeback_queue.
// master = producer/decode side, slave = the queue itself.
interface rf_writeback_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            mem_valid;
   logic            mem_ready;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            we3;
   logic [4:0]      a3;
   logic [XLEN-1:0] wd3;
   logic [4:0]      chk_a1;
   logic [4:0]      chk_a2;
   logic            busy1;
   logic            busy2;
   logic            fwd1_valid;
   logic            fwd2_valid;
   logic [XLEN-1:0] fwd1_data;
   logic [XLEN-1:0] fwd2_data;
   logic [CW-1:0]   count;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_a1, chk_a2,
      input  alu_ready, mem_ready, we3, a3, wd3, busy1, busy2,
             fwd1_valid, fwd2_valid, fwd1_data, fwd2_data, count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_a1, chk_a2,
      output alu_ready, mem_ready, we3, a3, wd3, busy1, busy2,
             fwd1_valid, fwd2_valid, fwd1_data, fwd2_data, count
   );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO merging ALU and load results onto the single register-file write port.
// Define RF_WBQ_BYPASS_EN to build the youngest-match forwarding path.
module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   rf_writeback_queue_if.slave  wb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] LAST2 = CW'(DEPTH - 2);

   logic [4:0]      r_rd   [DEPTH];
   logic [XLEN-1:0] r_data [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   logic            w_mem_ready;
   logic            w_alu_ready;
   logic            w_mem_push;
   logic            w_alu_push;
   logic            w_pop;
   logic [PW-1:0]   w_alu_slot;
   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_hit1;
   logic [DEPTH-1:0] w_hit2;

   // Readiness uses the registered count only; a same-cycle pop never frees a slot.
   assign w_mem_ready = (r_count < FULL);
   assign w_alu_ready = wb.mem_valid ? (r_count <= LAST2) : (r_count < FULL);
   assign w_mem_push  = wb.mem_valid & w_mem_ready & (wb.mem_rd != 5'd0);
   assign w_alu_push  = wb.alu_valid & w_alu_ready & (wb.alu_rd != 5'd0);
   assign w_pop       = (r_count != '0);
   assign w_alu_slot  = w_mem_push ? (r_tail + PW'(1)) : r_tail;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_mem_push) begin
            r_rd[r_tail]   <= wb.mem_rd;
            r_data[r_tail] <= wb.mem_data;
         end
         if (w_alu_push) begin
            r_rd[w_alu_slot]   <= wb.alu_rd;
            r_data[w_alu_slot] <= wb.alu_data;
         end
         r_head  <= r_head + PW'(w_pop);
         r_tail  <= r_tail + PW'(w_mem_push) + PW'(w_alu_push);
         r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
      end
   end

   always_comb begin
      logic [PW-1:0] v_off;
      v_off   = '0;
      w_valid = '0;
      w_hit1  = '0;
      w_hit2  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         v_off      = PW'(i) - r_head;
         w_valid[i] = ({1'b0, v_off} < r_count);
         w_hit1[i]  = w_valid[i] && (r_rd[i] == wb.chk_a1);
         w_hit2[i]  = w_valid[i] && (r_rd[i] == wb.chk_a2);
      end
   end

   assign wb.mem_ready = w_mem_ready;
   assign wb.alu_ready = w_alu_ready;
   assign wb.we3       = w_pop;
   assign wb.a3        = w_pop ? r_rd[r_head]   : '0;
   assign wb.wd3       = w_pop ? r_data[r_head] : '0;
   assign wb.busy1     = (wb.chk_a1 != 5'd0) && (|w_hit1);
   assign wb.busy2     = (wb.chk_a2 != 5'd0) && (|w_hit2);
   assign wb.count     = r_count;

`ifdef RF_WBQ_BYPASS_EN
   logic [XLEN-1:0] w_fwd1;
   logic [XLEN-1:0] w_fwd2;

   always_comb begin
      logic [PW-1:0] v_idx;
      v_idx  = '0;
      w_fwd1 = '0;
      w_fwd2 = '0;
      // Walk oldest to youngest so the youngest matching entry is the one left selected.
      for (int unsigned k = 0; k < DEPTH; k++) begin
         v_idx = r_head + PW'(k);
         if (w_hit1[v_idx]) w_fwd1 = r_data[v_idx];
         if (w_hit2[v_idx]) w_fwd2 = r_data[v_idx];
      end
   end

   assign wb.fwd1_valid = wb.busy1;
   assign wb.fwd2_valid = wb.busy2;
   assign wb.fwd1_data  = w_fwd1;
   assign wb.fwd2_data  = w_fwd2;
`else
   assign wb.fwd1_valid = 1'b0;
   assign wb.fwd2_valid = 1'b0;
   assign wb.fwd1_data  = '0;
   assign wb.fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: directed scenarios plus a random burst,
// with a per-cycle queue model checking retire order, readiness, count and hazard flags.
module tb_rf_writeback_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   logic [4+XLEN:0] sb [$];

   rf_writeback_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) wb ();

   rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb)
   );

   always #5 clk = ~clk;

   // Model: expectations formed from the queued entries, then advanced as the next edge will.
   always @(negedge clk) begin
      int unsigned     sz;
      logic            em, ea, eb1, eb2;
      logic [XLEN-1:0] ef1, ef2;
      if (reset) begin
         sb.delete();
      end else begin
         sz  = sb.size();
         em  = (sz < DEPTH);
         ea  = wb.mem_valid ? (sz + 2 <= DEPTH) : (sz < DEPTH);
         eb1 = 1'b0; eb2 = 1'b0; ef1 = '0; ef2 = '0;
         for (int i = 0; i < int'(sz); i++) begin
            if (wb.chk_a1 != 5'd0 && sb[i][XLEN+4:XLEN] == wb.chk_a1) begin eb1 = 1'b1; ef1 = sb[i][XLEN-1:0]; end
            if (wb.chk_a2 != 5'd0 && sb[i][XLEN+4:XLEN] == wb.chk_a2) begin eb2 = 1'b1; ef2 = sb[i][XLEN-1:0]; end
         end
         vectors++;
         if (wb.we3 !== (sz != 0)) begin miscompares++; $display("FAIL sb_we3: got %b expected %b", wb.we3, (sz != 0)); end
         if (sz != 0) begin
            vectors++;
            if ({wb.a3, wb.wd3} !== sb[0]) begin
               miscompares++;
               $display("FAIL sb_retire: got rd=%0d data=%h expected rd=%0d data=%h", wb.a3, wb.wd3, sb[0][XLEN+4:XLEN], sb[0][XLEN-1:0]);
            end
         end
         vectors++;
         if (wb.count !== CW'(sz)) begin miscompares++; $display("FAIL sb_count: got %0d expected %0d", wb.count, sz); end
         vectors++;
         if (wb.mem_ready !== em || wb.alu_ready !== ea) begin
            miscompares++;
            $display("FAIL sb_ready: got mem=%b alu=%b expected mem=%b alu=%b", wb.mem_ready, wb.alu_ready, em, ea);
         end
         vectors++;
         if (wb.busy1 !== eb1 || wb.busy2 !== eb2) begin
            miscompares++;
            $display("FAIL sb_busy: got %b%b expected %b%b", wb.busy1, wb.busy2, eb1, eb2);
         end
`ifdef RF_WBQ_BYPASS_EN
         vectors++;
         if (wb.fwd1_valid !== eb1 || wb.fwd2_valid !== eb2 || wb.fwd1_data !== ef1 || wb.fwd2_data !== ef2) begin
            miscompares++;
            $display("FAIL sb_fwd: got %b/%h %b/%h expected %b/%h %b/%h", wb.fwd1_valid, wb.fwd1_data,
                     wb.fwd2_valid, wb.fwd2_data, eb1, ef1, eb2, ef2);
         end
`else
         vectors++;
         if (wb.fwd1_valid !== 1'b0 || wb.fwd2_valid !== 1'b0 || wb.fwd1_data !== '0 || wb.fwd2_data !== '0) begin
            miscompares++;
            $display("FAIL sb_fwd_off: got %b/%h %b/%h expected all zero", wb.fwd1_valid, wb.fwd1_data, wb.fwd2_valid, wb.fwd2_data);
         end
`endif
         if (sz != 0) sb.pop_front();
         if (wb.mem_valid && em && wb.mem_rd != 5'd0) sb.push_back({wb.mem_rd, wb.mem_data});
         if (wb.alu_valid && ea && wb.alu_rd != 5'd0) sb.push_back({wb.alu_rd, wb.alu_data});
      end
   end

   task automatic drive_idle();
      wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
      wb.mem_valid = 1'b0; wb.mem_rd = '0; wb.mem_data = '0;
   endtask

   task automatic test_reset();
      drive_idle();
      wb.chk_a1 = 5'd5; wb.chk_a2 = 5'd0;
      #2;
      vectors++;
      if (wb.count !== '0 || wb.we3 !== 1'b0 || wb.a3 !== '0 || wb.wd3 !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got count=%0d we3=%b a3=%0d wd3=%h expected 0 0 0 0", wb.count, wb.we3, wb.a3, wb.wd3);
      end
      vectors++;
      if (wb.busy1 !== 1'b0 || wb.fwd1_valid !== 1'b0 || wb.mem_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_flags: got busy1=%b fwd1=%b mem_ready=%b expected 0 0 1", wb.busy1, wb.fwd1_valid, wb.mem_ready);
      end
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic test_single_push();
      @(posedge clk); #1;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'h0000_0006;
      #1 vectors++;
      if (wb.alu_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b expected 1", wb.alu_ready); end
      @(posedge clk); #1 drive_idle();
      vectors++;
      if (wb.we3 !== 1'b1 || wb.a3 !== 5'd5 || wb.wd3 !== 32'h6 || wb.count !== CW'(1)) begin
         miscompares++;
         $display("FAIL single_retire: got we3=%b a3=%0d wd3=%h count=%0d expected 1 5 6 1", wb.we3, wb.a3, wb.wd3, wb.count);
      end
      @(posedge clk); #1 vectors++;
      if (wb.count !== '0 || wb.we3 !== 1'b0) begin
         miscompares++;
         $display("FAIL single_drain: got count=%0d we3=%b expected 0 0", wb.count, wb.we3);
      end
   endtask

   task automatic test_dual_push();
      @(posedge clk); #1;
      wb.mem_valid = 1'b1; wb.mem_rd = 5'd9;  wb.mem_data = 32'h4;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd10; wb.alu_data = 32'hA;
      @(posedge clk); #1 drive_idle();
      vectors++;
      if (wb.count !== CW'(2) || wb.a3 !== 5'd9 || wb.wd3 !== 32'h4) begin
         miscompares++;
         $display("FAIL dual_first: got count=%0d a3=%0d wd3=%h expected 2 9 4", wb.count, wb.a3, wb.wd3);
      end
      @(posedge clk); #1 vectors++;
      if (wb.count !== CW'(1) || wb.a3 !== 5'd10 || wb.wd3 !== 32'hA) begin
         miscompares++;
         $display("FAIL dual_second: got count=%0d a3=%0d wd3=%h expected 1 10 a", wb.count, wb.a3, wb.wd3);
      end
      @(posedge clk); #1 vectors++;
      if (wb.count !== '0) begin miscompares++; $display("FAIL dual_drain: got count=%0d expected 0", wb.count); end
   endtask

   task automatic test_full();
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         wb.mem_valid = 1'b1; wb.mem_rd = 5'(1 + n);  wb.mem_data = $urandom;
         wb.alu_valid = 1'b1; wb.alu_rd = 5'(16 + n); wb.alu_data = $urandom;
      end
      #1 vectors++;
      if (wb.count !== CW'(3) || wb.mem_ready !== 1'b1 || wb.alu_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_one_slot: got count=%0d mem_ready=%b alu_ready=%b expected 3 1 0", wb.count, wb.mem_ready, wb.alu_ready);
      end
      wb.mem_valid = 1'b0;
      #1 vectors++;
      if (wb.alu_ready !== 1'b1) begin miscompares++; $display("FAIL full_alu_alone: got %b expected 1", wb.alu_ready); end
      drive_idle();
      repeat (5) @(posedge clk);
      #1 vectors++;
      if (wb.count !== '0) begin miscompares++; $display("FAIL full_drain: got count=%0d expected 0", wb.count); end
   endtask

   task automatic test_x0_discard();
      @(posedge clk); #1;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h0000_DEAD;
      #1 vectors++;
      if (wb.alu_ready !== 1'b1) begin miscompares++; $display("FAIL x0_ready: got %b expected 1", wb.alu_ready); end
      @(posedge clk); #1 drive_idle();
      vectors++;
      if (wb.count !== '0 || wb.we3 !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_discard: got count=%0d we3=%b expected 0 0", wb.count, wb.we3);
      end
   endtask

   task automatic test_hazard();
      @(posedge clk); #1;
      wb.mem_valid = 1'b1; wb.mem_rd = 5'd7; wb.mem_data = 32'h11;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h22;
      wb.chk_a1 = 5'd7; wb.chk_a2 = 5'd0;
      #1 vectors++;
      if (wb.busy1 !== 1'b0) begin miscompares++; $display("FAIL hazard_same_cycle: got busy1=%b expected 0", wb.busy1); end
      @(posedge clk); #1 drive_idle();
      vectors++;
      if (wb.busy1 !== 1'b1 || wb.busy2 !== 1'b0 || wb.count !== CW'(2)) begin
         miscompares++;
         $display("FAIL hazard_busy: got busy1=%b busy2=%b count=%0d expected 1 0 2", wb.busy1, wb.busy2, wb.count);
      end
`ifdef RF_WBQ_BYPASS_EN
      vectors++;
      if (wb.fwd1_valid !== 1'b1 || wb.fwd1_data !== 32'h22) begin
         miscompares++;
         $display("FAIL hazard_fwd: got %b/%h expected 1/00000022", wb.fwd1_valid, wb.fwd1_data);
      end
`endif
      @(posedge clk); #1 vectors++;
      if (wb.busy1 !== 1'b1 || wb.wd3 !== 32'h22) begin
         miscompares++;
         $display("FAIL hazard_last: got busy1=%b wd3=%h expected 1 00000022", wb.busy1, wb.wd3);
      end
      @(posedge clk); #1 vectors++;
      if (wb.busy1 !== 1'b0) begin miscompares++; $display("FAIL hazard_clear: got busy1=%b expected 0", wb.busy1); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      wb.mem_valid = 1'b1; wb.mem_rd = 5'd3; wb.mem_data = 32'h33;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd4; wb.alu_data = 32'h44;
      @(posedge clk); #1;
      wb.mem_rd = 5'd5; wb.mem_data = 32'h55;
      wb.alu_rd = 5'd6; wb.alu_data = 32'h66;
      wb.chk_a1 = 5'd6;
      @(posedge clk); #1 drive_idle();
      vectors++;
      if (wb.count !== CW'(3) || wb.busy1 !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_setup: got count=%0d busy1=%b expected 3 1", wb.count, wb.busy1);
      end
      #1 reset = 1'b1;
      #1 vectors++;
      if (wb.count !== '0 || wb.we3 !== 1'b0 || wb.busy1 !== 1'b0 || wb.a3 !== '0) begin
         miscompares++;
         $display("FAIL mid_reset: got count=%0d we3=%b busy1=%b a3=%0d expected 0 0 0 0", wb.count, wb.we3, wb.busy1, wb.a3);
      end
      @(posedge clk); #1 reset = 1'b0;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd8; wb.alu_data = 32'h88;
      @(posedge clk); #1 drive_idle();
      vectors++;
      if (wb.we3 !== 1'b1 || wb.a3 !== 5'd8 || wb.wd3 !== 32'h88 || wb.count !== CW'(1)) begin
         miscompares++;
         $display("FAIL mid_after: got we3=%b a3=%0d wd3=%h count=%0d expected 1 8 88 1", wb.we3, wb.a3, wb.wd3, wb.count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         wb.mem_valid = 1'($urandom_range(0, 1)); wb.mem_rd = 5'($urandom_range(0, 7)); wb.mem_data = $urandom;
         wb.alu_valid = 1'($urandom_range(0, 1)); wb.alu_rd = 5'($urandom_range(0, 7)); wb.alu_data = $urandom;
         wb.chk_a1 = 5'($urandom_range(0, 7)); wb.chk_a2 = 5'($urandom_range(0, 7));
      end
      @(posedge clk); #1 drive_idle();
      repeat (5) @(posedge clk);
      #1 vectors++;
      if (wb.count !== '0) begin miscompares++; $display("FAIL b2b_drain: got count=%0d expected 0", wb.count); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_dual_push();
      test_full();
      test_x0_discard();
      test_hazard();
      test_reset_mid();
      test_back_to_back();
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
